// File: rtl/datapath_sequencer_if.sv
// Host and datapath signal bundle for the microprogrammed sequencer.
// master = host/board side (drives program, start, step and the zero flag),
// slave  = sequencer (drives datapath controls and display status).
interface datapath_sequencer_if;
  // host control and program load
  logic        start;
  logic        step_en;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  // datapath feedback
  logic        zero;
  // datapath controls
  logic [1:0]  op_sel;
  logic        en_x;
  logic        en_y;
  logic        y_sel;
  // display / status
  logic [3:0]  pc;
  logic [1:0]  state_disp;
  logic        busy;
  logic        done;
  logic [7:0]  cycles;

  modport master (
    output start, step_en, prog_we, prog_addr, prog_data, zero,
    input  op_sel, en_x, en_y, y_sel, pc, state_disp, busy, done, cycles
  );

  modport slave (
    input  start, step_en, prog_we, prog_addr, prog_data, zero,
    output op_sel, en_x, en_y, y_sel, pc, state_disp, busy, done, cycles
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Microprogrammed sequencer for the x/y datapath. A 16x12 writable control
// store is read combinationally at pc; the decoded word drives the datapath
// in the same cycle and selects the next pc (SEQ/JMP/BZ/BNZ/HALT).
module datapath_sequencer (
  input  logic                  clk,
  input  logic                  reset,
  datapath_sequencer_if.slave   bus
);
  typedef struct packed {
    logic [1:0] op_sel;
    logic       en_x;
    logic       en_y;
    logic       y_sel;
    logic [2:0] next_ctl;
    logic [3:0] target;
  } instr_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] NC_SEQ = 3'b000;
  localparam logic [2:0] NC_JMP = 3'b001;
  localparam logic [2:0] NC_BZ  = 3'b010;
  localparam logic [2:0] NC_BNZ = 3'b011;

  // HALT with no enables; what every word holds after reset
  localparam logic [11:0] HALT_WORD = 12'h040;

  logic [11:0] mem [16];
  logic [1:0]  state;
  logic [3:0]  pc;
  logic [7:0]  cycles;

  instr_t      ir;
  logic        run;
  logic        halt_op;
  logic        advance;
  logic [3:0]  pc_inc;
  logic [3:0]  pc_next;
  logic [7:0]  cycles_inc;

  assign ir         = instr_t'(mem[pc]);
  assign run        = (state == S_RUN);
  // any next_ctl with the top bit set is HALT (reserved codes included)
  assign halt_op    = ir.next_ctl[2];
  assign advance    = run && bus.step_en;
  assign pc_inc     = pc + 4'd1;
  assign cycles_inc = (cycles == 8'hFF) ? cycles : cycles + 8'd1;

  // next-pc selection; branches look at zero from this same cycle
  always_comb begin
    pc_next = pc;
    case (ir.next_ctl)
      NC_SEQ:  pc_next = pc_inc;
      NC_JMP:  pc_next = ir.target;
      NC_BZ:   pc_next = bus.zero ? ir.target : pc_inc;
      NC_BNZ:  pc_next = bus.zero ? pc_inc : ir.target;
      default: pc_next = pc;
    endcase
  end

  // datapath controls: live only in RUN; enables also need step_en and a non-HALT word
  always_comb begin
    bus.op_sel = 2'b00;
    bus.en_x   = 1'b0;
    bus.en_y   = 1'b0;
    bus.y_sel  = 1'b0;
    if (run) begin
      bus.op_sel = ir.op_sel;
      bus.y_sel  = ir.y_sel;
      bus.en_x   = bus.step_en && ir.en_x && !halt_op;
      bus.en_y   = bus.step_en && ir.en_y && !halt_op;
    end
  end

  assign bus.pc         = pc;
  assign bus.state_disp = state;
  assign bus.busy       = run;
  assign bus.done       = (state == S_DONE);
  assign bus.cycles     = cycles;

  // control store: cleared to HALT on reset, writable only outside RUN
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= HALT_WORD;
    end else if (bus.prog_we && !run) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // sequencer state, pc and executed-instruction counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      pc     <= 4'd0;
      cycles <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state  <= S_RUN;
            pc     <= 4'd0;
            cycles <= 8'd0;
          end
        end
        S_RUN: begin
          if (advance) begin
            cycles <= cycles_inc;
            if (halt_op) state <= S_DONE;
            else         pc    <= pc_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: each cycle a behavioural model pushes the
// expected observation to exp_q and the sampled DUT observation goes to got_q;
// each test task drains and compares them, plus scenario-specific checks.
module tb_datapath_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  datapath_sequencer_if bus();
  datapath_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

  // observation: {pc[20:17], state[16:15], busy[14], done[13], op[12:11], en_x[10], en_y[9], y_sel[8], cycles[7:0]}
  typedef logic [20:0] obs_t;
  obs_t exp_q[$];
  obs_t got_q[$];
  int   checks = 0;
  int   passed = 0;

  logic [11:0] m_mem [16];
  logic [1:0]  m_st;
  logic [3:0]  m_pc;
  logic [7:0]  m_cyc;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 12'h040;
    m_st = 2'd0; m_pc = 4'd0; m_cyc = 8'd0;
  endtask

  // one clock: drive inputs, predict outputs, advance model, sample DUT at negedge
  task automatic cyc(input bit rn, input bit st, input bit step, input bit we,
                     input logic [3:0] a, input logic [11:0] d, input bit z);
    logic [11:0] w;
    bit run, hlt;
    obs_t e;
    reset = rn; bus.start = st; bus.step_en = step; bus.prog_we = we;
    bus.prog_addr = a; bus.prog_data = d; bus.zero = z;
    w = m_mem[m_pc]; run = (m_st == 2'd1); hlt = w[6];
    e = {m_pc, m_st, run, (m_st == 2'd2), (run ? w[11:10] : 2'b00),
         (run & step & w[9] & !hlt), (run & step & w[8] & !hlt), (run & w[7]), m_cyc};
    exp_q.push_back(e);
    if (!rn) model_reset();
    else if (!run) begin
      if (we) m_mem[a] = d;
      if (st) begin m_st = 2'd1; m_pc = 4'd0; m_cyc = 8'd0; end
    end else if (step) begin
      if (m_cyc != 8'hFF) m_cyc = m_cyc + 8'd1;
      case (w[6:4])
        3'd0: m_pc = m_pc + 4'd1;
        3'd1: m_pc = w[3:0];
        3'd2: m_pc = z ? w[3:0] : m_pc + 4'd1;
        3'd3: m_pc = z ? m_pc + 4'd1 : w[3:0];
        default: m_st = 2'd2;
      endcase
    end
    @(negedge clk);
    got_q.push_back({bus.pc, bus.state_disp, bus.busy, bus.done, bus.op_sel,
                     bus.en_x, bus.en_y, bus.y_sel, bus.cycles});
    @(posedge clk); #1;
  endtask

  task automatic idle();                               cyc(1, 0, 1, 0, 4'd0, 12'h0, 0); endtask
  task automatic wr(input logic [3:0] a, input logic [11:0] d); cyc(1, 0, 1, 1, a, d, 0); endtask
  task automatic go();                                 cyc(1, 1, 1, 0, 4'd0, 12'h0, 0); endtask
  task automatic run1(input bit step, input bit z);    cyc(1, 0, step, 0, 4'd0, 12'h0, z); endtask

  task automatic test_reset();
    obs_t e, g;
    cyc(0, 1, 1, 1, 4'd0, 12'hE00, 0);
    cyc(0, 1, 1, 1, 4'd0, 12'hE00, 0);
    idle();
    go();
    run1(1, 0);
    checks++;
    if (got_q[$][14] !== 1'b1 || got_q[$][12:8] !== 5'b0)
      $display("FAIL reset_halt_at_pc0 busy=%b ctl=%b required busy=1 ctl=00000", got_q[$][14], got_q[$][12:8]);
    else passed++;
    checks++;
    if (bus.done !== 1'b1 || bus.cycles !== 8'd1)
      $display("FAIL reset_done done=%b cycles=%0d required 1/1", bus.done, bus.cycles);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL reset_trace got=%h required=%h", g, e); else passed++;
    end
  endtask

  task automatic test_countdown();
    obs_t e, g;
    logic [3:0] pcs [6];
    logic       exs [6];
    logic [3:0] want_pc [6];
    bit         zs [6];
    want_pc = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
    zs      = '{0, 0, 0, 0, 1, 0};
    wr(4'd0, 12'hE00); wr(4'd1, 12'h531); wr(4'd2, 12'h040);
    go();
    for (int i = 0; i < 6; i++) begin
      run1(1, zs[i]);
      pcs[i] = got_q[$][20:17]; exs[i] = got_q[$][10];
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (pcs[i] !== want_pc[i] || exs[i] !== (i == 0))
        $display("FAIL countdown_pc[%0d] pc=%0d en_x=%b required pc=%0d en_x=%b", i, pcs[i], exs[i], want_pc[i], (i == 0));
      else passed++;
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cycles !== 8'd6)
      $display("FAIL countdown_end done=%b busy=%b cycles=%0d required 1/0/6", bus.done, bus.busy, bus.cycles);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL countdown_trace got=%h required=%h", g, e); else passed++;
    end
  endtask

  task automatic test_step_gating();
    obs_t e, g;
    int k = 0;
    bit step, z;
    go();
    for (int i = 0; i < 40 && m_st == 2'd1; i++) begin
      step = (i % 2 == 0);
      if (step) begin
        z = (m_pc == 4'd1) && (k >= 3);
        if (m_pc == 4'd1) k++;
      end else z = 1'($urandom_range(0, 1));
      run1(step, z);
      if (!step) begin
        checks++;
        if (got_q[$][10:9] !== 2'b00)
          $display("FAIL step_frozen_en[%0d] en_x/en_y=%b required 00", i, got_q[$][10:9]);
        else passed++;
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.cycles !== 8'd6)
      $display("FAIL step_end done=%b cycles=%0d required 1/6", bus.done, bus.cycles);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL step_trace got=%h required=%h", g, e); else passed++;
    end
  endtask

  task automatic test_write_protect();
    obs_t e, g;
    go();
    cyc(1, 0, 1, 1, 4'd2, 12'h000, 0);
    run1(1, 1);
    run1(1, 0);
    checks++;
    if (bus.done !== 1'b1 || bus.pc !== 4'd2 || bus.cycles !== 8'd3)
      $display("FAIL wp_halt done=%b pc=%0d cycles=%0d required 1/2/3", bus.done, bus.pc, bus.cycles);
    else passed++;
    cyc(1, 1, 1, 1, 4'd0, 12'h040, 0);
    run1(1, 0);
    checks++;
    if (bus.done !== 1'b1 || bus.pc !== 4'd0 || bus.cycles !== 8'd1)
      $display("FAIL wp_restart done=%b pc=%0d cycles=%0d required 1/0/1", bus.done, bus.pc, bus.cycles);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL wp_trace got=%h required=%h", g, e); else passed++;
    end
  endtask

  task automatic test_reset_mid_run();
    obs_t e, g;
    wr(4'd0, 12'hE00);
    go();
    run1(1, 0);
    run1(1, 0);
    cyc(0, 0, 1, 0, 4'd0, 12'h0, 0);
    checks++;
    if (bus.state_disp !== 2'd0 || bus.pc !== 4'd0 || bus.cycles !== 8'd0 || bus.busy !== 1'b0)
      $display("FAIL midreset_idle state=%0d pc=%0d cycles=%0d busy=%b required 0/0/0/0",
               bus.state_disp, bus.pc, bus.cycles, bus.busy);
    else passed++;
    go();
    run1(1, 0);
    checks++;
    if (bus.done !== 1'b1 || bus.cycles !== 8'd1)
      $display("FAIL midreset_store_cleared done=%b cycles=%0d required 1/1", bus.done, bus.cycles);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL midreset_trace got=%h required=%h", g, e); else passed++;
    end
  endtask

  task automatic test_wrap_saturate();
    obs_t e, g;
    bit saw_done = 0;
    for (int i = 0; i < 16; i++) wr(4'(i), (i == 15) ? 12'h000 : 12'h01F);
    go();
    for (int i = 0; i < 300; i++) begin
      run1(1, 1'($urandom_range(0, 1)));
      if (got_q[$][13]) saw_done = 1;
    end
    checks++;
    if (bus.cycles !== 8'd255 || saw_done || bus.busy !== 1'b1)
      $display("FAIL wrap_saturate cycles=%0d saw_done=%b busy=%b required 255/0/1", bus.cycles, saw_done, bus.busy);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) $display("FAIL wrap_trace got=%h required=%h", g, e); else passed++;
    end
  endtask

  initial begin
    reset = 1'b0; bus.start = 1'b0; bus.step_en = 1'b0; bus.prog_we = 1'b0;
    bus.prog_addr = 4'd0; bus.prog_data = 12'h0; bus.zero = 1'b0;
    @(posedge clk); #1;
    model_reset();
    test_reset();
    test_countdown();
    test_step_gating();
    test_write_protect();
    test_reset_mid_run();
    test_wrap_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
